pfb_input_buffer: RTL and testbench

Input stage of the oversampled polyphase filter bank; sits directly downstream of the ADC sample source. Accepts D new complex samples per frame into an M-deep circular history buffer, then replays the M most recent samples, newest first, as one output frame. This implements the M/D overlap required by the oversampled PFB. Because the ADC source ignores backpressure, samples offered while the buffer is replaying are dropped and counted.

---
 rtl/pfb_pkg.sv | 20 ++
 rtl/sample_ring.sv | 30 +++
 rtl/pfb_input_buffer.sv | 113 +++++++++++
 tb/tb_pfb_input_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pfb_pkg.sv
// Shared types and defaults for the polyphase filter bank input stage.
package pfb_pkg;

  localparam int M_DEF     = 8;
  localparam int D_DEF     = 6;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic signed [WIDTH_DEF/2-1:0] im;
    logic signed [WIDTH_DEF/2-1:0] re;
  } cx_t;

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sample_ring.sv
// M-entry sample history: one synchronous write port, one asynchronous read port.
module sample_ring
  import pfb_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = ptr_w(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [M];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < M; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pfb_input_buffer.sv
// PFB input stage: collects D new samples per frame, then replays the M newest
// samples newest-first. Samples offered during replay are dropped and counted.
module pfb_input_buffer
  import pfb_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int D     = D_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = ptr_w(M);
  localparam logic [AW-1:0] IN_LAST  = AW'(D - 1);
  localparam logic [AW-1:0] OUT_LAST = AW'(M - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state, state_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr, in_cnt, out_cnt, out_cnt_nxt;
  logic             rdy_p0, vld_p0, last_p0;
  logic             rdy_nxt, vld_nxt, last_nxt;
  logic             acc, ohs, frame_in_done, frame_out_done;
  logic [WIDTH-1:0] ring_rdata;
  logic [CNT_W-1:0] drop_p0;

  assign acc            = s_axis_tvalid & rdy_p0;
  assign ohs            = vld_p0 & m_axis_tready;
  assign frame_in_done  = acc & (in_cnt == IN_LAST);
  assign frame_out_done = ohs & (out_cnt == OUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (frame_in_done)  state_nxt = EMIT;
      EMIT:    if (frame_out_done) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Handshake outputs are registered from the next state so no input reaches an output combinationally.
  always_comb begin
    out_cnt_nxt = out_cnt;
    if (frame_in_done)  out_cnt_nxt = '0;
    else if (ohs)       out_cnt_nxt = out_cnt + AW'(1);
    rdy_nxt  = (state_nxt == FILL);
    vld_nxt  = (state_nxt == EMIT);
    last_nxt = vld_nxt && (out_cnt_nxt == OUT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      rdy_p0  <= 1'b0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      drop_p0 <= '0;
    end else begin
      if (acc) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (frame_in_done) begin
          in_cnt <= '0;
          rd_ptr <= wr_ptr;
        end else begin
          in_cnt <= in_cnt + AW'(1);
        end
      end
      if (ohs) rd_ptr <= rd_ptr - AW'(1);
      out_cnt <= out_cnt_nxt;
      rdy_p0  <= rdy_nxt;
      vld_p0  <= vld_nxt;
      last_p0 <= last_nxt;
      if (s_axis_tvalid && !rdy_p0) drop_p0 <= sat_inc(drop_p0);
    end
  end

  sample_ring #(.M(M), .WIDTH(WIDTH)) u_ring (
    .clk   (clk),
    .rst   (rst),
    .we    (acc),
    .waddr (wr_ptr),
    .wdata (s_axis_tdata),
    .raddr (rd_ptr),
    .rdata (ring_rdata)
  );

  assign s_axis_tready = rdy_p0;
  assign m_axis_tvalid = vld_p0;
  assign m_axis_tlast  = last_p0;
  assign m_axis_tdata  = vld_p0 ? ring_rdata : '0;
  assign drop_cnt      = drop_p0;

endmodule

// File: tb/tb_pfb_input_buffer.sv
// Directed bench for pfb_input_buffer: M=8/D=6 instance plus an M=D=8 instance with a narrow drop counter.
module tb_pfb_input_buffer;
  import pfb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_din, a_dat, b_din, b_dat;
  logic        a_vin, a_rdy, a_vld, a_ordy, a_last;
  logic        b_vin, b_rdy, b_vld, b_ordy, b_last;
  logic [15:0] a_drop;
  logic [3:0]  b_drop;

  pfb_input_buffer #(.M(8), .D(6), .WIDTH(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(a_din), .s_axis_tvalid(a_vin), .s_axis_tready(a_rdy),
    .m_axis_tdata(a_dat), .m_axis_tvalid(a_vld), .m_axis_tready(a_ordy),
    .m_axis_tlast(a_last), .drop_cnt(a_drop)
  );

  pfb_input_buffer #(.M(8), .D(8), .WIDTH(32), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_din), .s_axis_tvalid(b_vin), .s_axis_tready(b_rdy),
    .m_axis_tdata(b_dat), .m_axis_tvalid(b_vld), .m_axis_tready(b_ordy),
    .m_axis_tlast(b_last), .drop_cnt(b_drop)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int i);
    cx_t c;
    c.re = 16'(i);
    c.im = -16'(i);
    return c;
  endfunction

  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic        ordy;
    logic        erdy;
    logic        evld;
    logic        elast;
    logic [31:0] edat;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] hist[$];

  task automatic add(input logic vin, input logic [31:0] din, input logic ordy,
                     input logic erdy, input logic evld, input logic elast,
                     input logic [31:0] edat);
    tbl.push_back(vec_t'{vin, din, ordy, erdy, evld, elast, edat});
  endtask

  task automatic add_fill(input int first);
    for (int i = 0; i < 6; i++) add(1'b1, mk(first + i), 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic add_emit(input int newest);
    for (int k = 0; k < 8; k++)
      add(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, k == 7, (newest - k >= 1) ? mk(newest - k) : 32'd0);
  endtask

  initial begin
    logic rp [10];
    int   k;
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Frames 1 and 2 with free-flowing output, frame 3 with a 1,0,0,1 ready pattern.
    add_fill(1);  add_emit(6);
    add_fill(7);  add_emit(12);
    add_fill(13);
    k = 0;
    for (int j = 0; j < 10; j++) begin
      add(1'b0, 32'd0, rp[j], 1'b0, 1'b1, k == 7, mk(18 - k));
      if (rp[j]) k++;
    end

    rst = 1'b1;
    a_vin = 1'b0; a_din = '0; a_ordy = 1'b1;
    b_vin = 1'b0; b_din = '0; b_ordy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy",  a_rdy,  1'b0);
    chk("rst_vld",  a_vld,  1'b0);
    chk("rst_last", a_last, 1'b0);
    chk("rst_dat",  a_dat,  32'd0);
    chk("rst_drop", a_drop, 16'd0);
    chk("rst_wptr", dut_a.wr_ptr, 3'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy", i),  a_rdy,  tbl[i].erdy);
      chk($sformatf("tbl%0d_vld", i),  a_vld,  tbl[i].evld);
      chk($sformatf("tbl%0d_last", i), a_last, tbl[i].elast);
      chk($sformatf("tbl%0d_dat", i),  a_dat,  tbl[i].edat);
      a_vin  = tbl[i].vin;
      a_din  = tbl[i].din;
      a_ordy = tbl[i].ordy;
    end

    // Source that never deasserts valid: 6 accepted, 8 dropped per frame.
    for (int i = 1; i <= 18; i++) hist.push_back(mk(i));
    for (int t = 0; t < 42; t++) begin
      int ph;
      @(negedge clk);
      ph = t % 14;
      if (t == 0) chk("wr_ptr_wrap", dut_a.wr_ptr, 3'd2);
      chk($sformatf("adc%0d_rdy", t), a_rdy, ph < 6);
      if (ph >= 6) begin
        chk($sformatf("adc%0d_vld", t),  a_vld,  1'b1);
        chk($sformatf("adc%0d_dat", t),  a_dat,  hist[hist.size() - 1 - (ph - 6)]);
        chk($sformatf("adc%0d_last", t), a_last, ph == 13);
      end
      a_vin = 1'b1;
      a_din = mk(100 + t);
      if (ph < 6) hist.push_back(mk(100 + t));
    end
    @(negedge clk);
    chk("adc_drop", a_drop, 16'd24);
    chk("adc_rdy_end", a_rdy, 1'b1);
    a_vin = 1'b0;

    // Reset in the middle of an output frame.
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("pre_rst_rdy", a_rdy, 1'b1);
      a_vin = 1'b1; a_din = mk(i);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      a_vin = 1'b0;
      chk($sformatf("pre_rst_dat%0d", j), a_dat, mk(6 - j));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy",  a_rdy,  1'b0);
    chk("mid_rst_vld",  a_vld,  1'b0);
    chk("mid_rst_dat",  a_dat,  32'd0);
    chk("mid_rst_drop", a_drop, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("post_rst_rdy", a_rdy, 1'b1);
      a_vin = 1'b1; a_din = mk(i);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      a_vin = 1'b0;
      chk($sformatf("post_rst_vld%0d", j),  a_vld,  1'b1);
      chk($sformatf("post_rst_dat%0d", j),  a_dat,  (j < 6) ? mk(6 - j) : 32'd0);
      chk($sformatf("post_rst_last%0d", j), a_last, j == 7);
    end
    @(negedge clk);
    chk("post_rst_idle_vld", a_vld, 1'b0);
    chk("post_rst_drop", a_drop, 16'd0);

    // D == M: no overlap, each frame is the last M inputs reversed.
    for (int f = 0; f < 2; f++) begin
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        chk("dm_rdy", b_rdy, 1'b1);
        b_vin = 1'b1; b_din = mk(8 * f + i);
      end
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        b_vin = 1'b0;
        chk($sformatf("dm%0d_dat%0d", f, j),  b_dat,  mk(8 * f + 8 - j));
        chk($sformatf("dm%0d_last%0d", f, j), b_last, j == 7);
      end
    end

    // Stalled output with valid held on the input: data held, drop counter saturates.
    for (int i = 17; i <= 24; i++) begin
      @(negedge clk);
      b_vin = 1'b1; b_din = mk(i);
    end
    b_ordy = 1'b0;
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_vld", s), b_vld, 1'b1);
      chk($sformatf("stall%0d_dat", s), b_dat, mk(24));
      b_vin = 1'b1; b_din = mk(999);
    end
    @(negedge clk);
    chk("sat_drop", b_drop, 4'd15);
    chk("drain_dat0", b_dat, mk(24));
    b_vin = 1'b0; b_ordy = 1'b1;
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      chk($sformatf("drain_dat%0d", j),  b_dat,  mk(24 - j));
      chk($sformatf("drain_last%0d", j), b_last, j == 7);
    end
    @(negedge clk);
    chk("drain_rdy", b_rdy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
